axi4_lite_slave_regfile: RTL and testbench

Parametrised AXI4-Lite slave that terminates all five channels into a bank of NUM_REGS memory-mapped registers.
- Write address and write data are accepted independently, in either order.
- Byte strobes are applied per lane; out-of-range addresses get SLVERR.
- An optional protection check rejects non-secure accesses.
- Sits behind the AXI4-Lite adaptor/interconnect as the generic register target for peripherals. Register contents are exported flat for hardware use.

---
 rtl/axi4_lite_pkg.sv | 27 ++
 rtl/axi4_lite_strb_merge.sv | 21 ++
 rtl/axi4_lite_slave_regfile.sv | 221 ++++++++++++++++++++++
 tb/tb_axi4_lite_slave_regfile.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM state encodings and address decode helper.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WIdle = 2'd0,
        WAddr = 2'd1,
        WData = 2'd2,
        WResp = 2'd3
    } wr_state_e;

    typedef enum logic {
        RIdle = 1'b0,
        RData = 1'b1
    } rd_state_e;

    // Word index of a byte address; the sub-word byte offset bits are dropped.
    function automatic logic [63:0] addr_to_index(input logic [63:0] addr,
                                                  input int unsigned addr_lsb);
        return addr >> addr_lsb;
    endfunction

endpackage

// File: rtl/axi4_lite_strb_merge.sv
// Per-byte merge of old and new register data under a write strobe mask.
module axi4_lite_strb_merge #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_data,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged_data
);

    // Lanes with a set strobe take the new byte, the rest keep the old byte.
    always_comb begin
        merged_data = old_data;
        for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
            if (strb[i]) begin
                merged_data[i*8 +: 8] = new_data[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave terminating all five channels into a bank of memory-mapped registers.
module axi4_lite_slave_regfile
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter bit          PROT_CHECK = 1'b0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);

    wr_state_e wr_state_q;
    rd_state_e rd_state_q;
    logic      ready_en_q;

    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic                  aw_nonsec_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic aw_hs, w_hs, ar_hs, commit;

    logic [ADDR_WIDTH-1:0] cm_addr;
    logic                  cm_nonsec;
    logic [DATA_WIDTH-1:0] cm_data;
    logic [STRB_WIDTH-1:0] cm_strb;
    logic [63:0]           cm_idx;
    logic                  cm_err;
    logic [DATA_WIDTH-1:0] cm_old;
    logic [DATA_WIDTH-1:0] cm_merged;

    logic [63:0]           ar_idx;
    logic                  ar_err;
    logic [DATA_WIDTH-1:0] ar_val;

    // Only prot[1] (non-secure) matters to this target.
    logic unused_prot;
    assign unused_prot = ^{awprot[2], awprot[0], arprot[2], arprot[0]};

    // Channel readies follow FSM state, held low until the first edge out of reset.
    always_comb begin
        awready = ready_en_q && ((wr_state_q == WIdle) || (wr_state_q == WData));
        wready  = ready_en_q && ((wr_state_q == WIdle) || (wr_state_q == WAddr));
        arready = ready_en_q && (rd_state_q == RIdle);
    end

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // A commit happens on whichever edge completes the second of the AW/W handshakes.
    always_comb begin
        commit = 1'b0;
        case (wr_state_q)
            WIdle:   commit = aw_hs && w_hs;
            WAddr:   commit = w_hs;
            WData:   commit = aw_hs;
            default: commit = 1'b0;
        endcase
    end

    // Commit operands come from the held copy when that channel arrived earlier.
    always_comb begin
        cm_addr   = (wr_state_q == WAddr) ? awaddr_q    : awaddr;
        cm_nonsec = (wr_state_q == WAddr) ? aw_nonsec_q : awprot[1];
        cm_data   = (wr_state_q == WData) ? wdata_q     : wdata;
        cm_strb   = (wr_state_q == WData) ? wstrb_q     : wstrb;
        cm_idx    = addr_to_index(64'(cm_addr), ADDR_LSB);
        cm_err    = (cm_idx >= 64'(NUM_REGS)) || (PROT_CHECK && cm_nonsec);
        cm_old    = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (cm_idx == 64'(i)) begin
                cm_old = regs_q[i];
            end
        end
    end

    axi4_lite_strb_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb_merge (
        .old_data    (cm_old),
        .new_data    (cm_data),
        .strb        (cm_strb),
        .merged_data (cm_merged)
    );

    // Read decode works straight off the pre-edge register state.
    always_comb begin
        ar_idx = addr_to_index(64'(araddr), ADDR_LSB);
        ar_err = (ar_idx >= 64'(NUM_REGS)) || (PROT_CHECK && arprot[1]);
        ar_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == 64'(i)) begin
                ar_val = regs_q[i];
            end
        end
    end

    // Ready enable rises on the first clock edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Write channel FSM: captures the early channel, issues the response after commit.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q  <= WIdle;
            awaddr_q    <= '0;
            aw_nonsec_q <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid      <= 1'b0;
            bresp       <= RESP_OKAY;
        end else if (commit) begin
            wr_state_q <= WResp;
            bvalid     <= 1'b1;
            bresp      <= cm_err ? RESP_SLVERR : RESP_OKAY;
        end else begin
            case (wr_state_q)
                WIdle: begin
                    if (aw_hs) begin
                        awaddr_q    <= awaddr;
                        aw_nonsec_q <= awprot[1];
                        wr_state_q  <= WAddr;
                    end else if (w_hs) begin
                        wdata_q    <= wdata;
                        wstrb_q    <= wstrb;
                        wr_state_q <= WData;
                    end
                end
                WResp: begin
                    if (bready) begin
                        bvalid     <= 1'b0;
                        wr_state_q <= WIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register bank: merged write on a clean commit, nothing on SLVERR.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit && !cm_err) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (cm_idx == 64'(i)) begin
                    regs_q[i] <= cm_merged;
                end
            end
        end
    end

    // Read channel FSM: registers data and response on AR, holds them until rready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= RIdle;
            rvalid     <= 1'b0;
            rdata      <= '0;
            rresp      <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                RIdle: begin
                    if (ar_hs) begin
                        rdata      <= ar_err ? '0 : ar_val;
                        rresp      <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        rvalid     <= 1'b1;
                        rd_state_q <= RData;
                    end
                end
                RData: begin
                    if (rready) begin
                        rvalid     <= 1'b0;
                        rd_state_q <= RIdle;
                    end
                end
                default: rd_state_q <= RIdle;
            endcase
        end
    end

    // Flat export of the register bank.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed bench for axi4_lite_slave_regfile (8 x 32-bit registers, protection check on).
module tb_axi4_lite_slave_regfile;

    logic         aclk;
    logic         aresetn;
    logic [31:0]  awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [255:0] regs_out;

    int checks = 0;
    int errors = 0;

    axi4_lite_slave_regfile #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (8),
        .PROT_CHECK (1'b1)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .awaddr   (awaddr),
        .awprot   (awprot),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arprot   (arprot),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .regs_out (regs_out)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Stimulus only: present AW and W together for one edge, return on the next negedge.
    task automatic drive_write(input logic [31:0] a, input logic [2:0] p,
                               input logic [31:0] d, input logic [3:0] s);
        awaddr = a; awprot = p; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    // Stimulus only: one AR handshake, return on the next negedge.
    task automatic drive_read(input logic [31:0] a, input logic [2:0] p);
        araddr = a; arprot = p; arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic release_b();
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic release_r();
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b1;
        awaddr = '0; awprot = '0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arprot = '0; bready = 1'b0; rready = 1'b0;
        awvalid = 1'b1; arvalid = 1'b1;
        #1 aresetn = 1'b0;
        repeat (4) begin
            @(negedge aclk);
            checks++;
            if ({awready, wready, arready} !== 3'b000) begin
                errors++;
                $display("FAIL reset_readies got %b want 000", {awready, wready, arready});
            end
        end
        #9 aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++;
            $display("FAIL pre_edge_readies got %b want 000", {awready, wready, arready});
        end
        checks++;
        if ({bvalid, rvalid, bresp, rresp, rdata} !== 38'd0 || regs_out !== 256'd0) begin
            errors++;
            $display("FAIL reset_outputs got bv=%b rv=%b rd=%h regs=%h want zeros",
                     bvalid, rvalid, rdata, regs_out);
        end
        awvalid = 1'b0; arvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL post_reset_readies got %b want 111", {awready, wready, arready});
        end
        checks++;
        if ({bvalid, rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_no_handshake got bv=%b rv=%b want 0 0", bvalid, rvalid);
        end
    endtask

    task automatic test_same_cycle_write();
        drive_write(32'd16, 3'd0, 32'hF0B4A596, 4'b1011);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL same_cycle_b got bv=%b br=%b want 1 00", bvalid, bresp);
        end
        checks++;
        if (regs_out[4*32 +: 32] !== 32'hF000A596) begin
            errors++;
            $display("FAIL same_cycle_reg4 got %h want f000a596", regs_out[4*32 +: 32]);
        end
        checks++;
        if ({awready, wready} !== 2'b00) begin
            errors++;
            $display("FAIL resp_readies got %b want 00", {awready, wready});
        end
        release_b();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_bdrop got %b want 0", bvalid);
        end
    endtask

    task automatic test_w_first();
        wdata = 32'h12345678; wstrb = 4'b0110; wvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0;
        checks++;
        if ({awready, wready} !== 2'b10) begin
            errors++;
            $display("FAIL w_first_readies got %b want 10", {awready, wready});
        end
        repeat (2) begin
            @(negedge aclk);
            checks++;
            if (bvalid !== 1'b0 || regs_out[5*32 +: 32] !== 32'h0) begin
                errors++;
                $display("FAIL w_first_early got bv=%b reg5=%h want 0 0",
                         bvalid, regs_out[5*32 +: 32]);
            end
        end
        awaddr = 32'd20; awprot = 3'd0; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        checks++;
        if (regs_out[5*32 +: 32] !== 32'h00345600) begin
            errors++;
            $display("FAIL w_first_reg5 got %h want 00345600", regs_out[5*32 +: 32]);
        end
        repeat (4) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00) begin
                errors++;
                $display("FAIL w_first_b_hold got bv=%b br=%b want 1 00", bvalid, bresp);
            end
            @(negedge aclk);
        end
        release_b();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL w_first_bdrop got %b want 0", bvalid);
        end
    endtask

    task automatic test_read();
        drive_read(32'd32, 3'd5);
        repeat (2) begin
            checks++;
            if (rvalid !== 1'b1 || rresp !== 2'b10 || rdata !== 32'h0) begin
                errors++;
                $display("FAIL read_oor got rv=%b rr=%b rd=%h want 1 10 0", rvalid, rresp, rdata);
            end
            @(negedge aclk);
        end
        release_r();
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL read_rdrop got %b want 0", rvalid);
        end
        drive_read(32'd16, 3'd0);
        checks++;
        if (rvalid !== 1'b1 || rresp !== 2'b00 || rdata !== 32'hF000A596) begin
            errors++;
            $display("FAIL read_reg4 got rv=%b rr=%b rd=%h want 1 00 f000a596",
                     rvalid, rresp, rdata);
        end
        release_r();
        // Byte offset bits are ignored: address 22 decodes to reg5.
        drive_read(32'd22, 3'd0);
        checks++;
        if (rresp !== 2'b00 || rdata !== 32'h00345600) begin
            errors++;
            $display("FAIL read_offset got rr=%b rd=%h want 00 00345600", rresp, rdata);
        end
        release_r();
    endtask

    task automatic test_prot_and_errors();
        drive_write(32'd4, 3'd3, 32'hAAAA5555, 4'hF);
        checks++;
        if (bresp !== 2'b10 || regs_out[1*32 +: 32] !== 32'h0) begin
            errors++;
            $display("FAIL prot_nonsec got br=%b reg1=%h want 10 0", bresp, regs_out[1*32 +: 32]);
        end
        release_b();
        drive_write(32'd4, 3'd1, 32'hAAAA5555, 4'hF);
        checks++;
        if (bresp !== 2'b00 || regs_out[1*32 +: 32] !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL prot_secure got br=%b reg1=%h want 00 aaaa5555",
                     bresp, regs_out[1*32 +: 32]);
        end
        release_b();
        drive_read(32'd4, 3'd2);
        checks++;
        if (rresp !== 2'b10 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL prot_read got rr=%b rd=%h want 10 0", rresp, rdata);
        end
        release_r();
        drive_write(32'd32, 3'd0, 32'hDEADBEEF, 4'hF);
        checks++;
        if (bresp !== 2'b10 || regs_out[0 +: 32] !== 32'h0) begin
            errors++;
            $display("FAIL oor_write got br=%b reg0=%h want 10 0", bresp, regs_out[0 +: 32]);
        end
        release_b();
        drive_write(32'd20, 3'd0, 32'hFFFFFFFF, 4'h0);
        checks++;
        if (bresp !== 2'b00 || regs_out[5*32 +: 32] !== 32'h00345600) begin
            errors++;
            $display("FAIL strb_zero got br=%b reg5=%h want 00 00345600",
                     bresp, regs_out[5*32 +: 32]);
        end
        release_b();
    endtask

    task automatic test_back_to_back();
        bready = 1'b1;
        awaddr = 32'd24; awprot = 3'd0; wdata = 32'h01020304; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        checks++;
        if (bvalid !== 1'b1 || regs_out[6*32 +: 32] !== 32'h01020304) begin
            errors++;
            $display("FAIL b2b_first got bv=%b reg6=%h want 1 01020304",
                     bvalid, regs_out[6*32 +: 32]);
        end
        wdata = 32'h0A0B0C0D; wstrb = 4'b0011;
        @(negedge aclk);
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap got bv=%b awr=%b want 0 1", bvalid, awready);
        end
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || regs_out[6*32 +: 32] !== 32'h01020C0D) begin
            errors++;
            $display("FAIL b2b_second got bv=%b reg6=%h want 1 01020c0d",
                     bvalid, regs_out[6*32 +: 32]);
        end
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic test_rw_collision();
        drive_write(32'd8, 3'd0, 32'h11112222, 4'hF);
        release_b();
        awaddr = 32'd8; awprot = 3'd0; wdata = 32'h33334444; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'd8; arprot = 3'd0; arvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h11112222) begin
            errors++;
            $display("FAIL collide_old got rv=%b rd=%h want 1 11112222", rvalid, rdata);
        end
        checks++;
        if (bvalid !== 1'b1 || regs_out[2*32 +: 32] !== 32'h33334444) begin
            errors++;
            $display("FAIL collide_write got bv=%b reg2=%h want 1 33334444",
                     bvalid, regs_out[2*32 +: 32]);
        end
        bready = 1'b1; rready = 1'b1;
        @(negedge aclk);
        bready = 1'b0; rready = 1'b0;
        drive_read(32'd8, 3'd0);
        checks++;
        if (rresp !== 2'b00 || rdata !== 32'h33334444) begin
            errors++;
            $display("FAIL collide_new got rr=%b rd=%h want 00 33334444", rresp, rdata);
        end
        release_r();
    endtask

    initial begin
        test_reset();
        test_same_cycle_write();
        test_w_first();
        test_read();
        test_prot_and_errors();
        test_back_to_back();
        test_rw_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
